// File: rtl/button_conditioner_if.sv
// Signal bundle between raw board buttons and the conditioned per-channel outputs.
// The slave side is the conditioner itself; the master side drives raw inputs and consumes results.
interface button_conditioner_if #(
    parameter int NUM_BTN = 5
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic [NUM_BTN-1:0] btn_toggle;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_toggle
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_toggle
    );
endinterface

// File: rtl/button_conditioner.sv
// Per-channel two-flop synchronizer and debounce counter producing a clean level,
// one-cycle press/release pulses and a press-driven toggle for each button.
module button_conditioner #(
    parameter int NUM_BTN         = 5,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    button_conditioner_if.slave btn
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_BTN-1:0] s1;
    logic [NUM_BTN-1:0] s2;
    logic [NUM_BTN-1:0] stable;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] rel;
    logic [NUM_BTN-1:0] toggle;
    logic [CNT_W-1:0]   cnt [NUM_BTN];

    logic [NUM_BTN-1:0] stable_next;
    logic [NUM_BTN-1:0] press_next;
    logic [NUM_BTN-1:0] rel_next;
    logic [NUM_BTN-1:0] toggle_next;
    logic [CNT_W-1:0]   cnt_next [NUM_BTN];

    // Any sample agreeing with the accepted level restarts qualification from zero.
    always_comb begin
        stable_next = stable;
        press_next  = '0;
        rel_next    = '0;
        toggle_next = toggle;
        for (int i = 0; i < NUM_BTN; i++) begin
            cnt_next[i] = cnt[i];
            if (s2[i] == stable[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] == CNT_MAX) begin
                cnt_next[i]    = '0;
                stable_next[i] = s2[i];
                press_next[i]  = s2[i];
                rel_next[i]    = ~s2[i];
                toggle_next[i] = toggle[i] ^ s2[i];
            end else begin
                cnt_next[i] = cnt[i] + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= '0;
            s2     <= '0;
            stable <= '0;
            press  <= '0;
            rel    <= '0;
            toggle <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1     <= btn.btn_raw;
            s2     <= s1;
            stable <= stable_next;
            press  <= press_next;
            rel    <= rel_next;
            toggle <= toggle_next;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    assign btn.btn_level   = stable;
    assign btn.btn_press   = press;
    assign btn.btn_release = rel;
    assign btn.btn_toggle  = toggle;
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a cycle-indexed scoreboard of expected outputs.
module tb_button_conditioner;
    localparam int NB  = 2;
    localparam int DB  = 4;
    // Posedges from driving btn_raw (between edges) until the outputs change.
    localparam int LAT = DB + 2;

    typedef struct {
        int          cycle;
        string       tag;
        logic [1:0]  level;
        logic [1:0]  press;
        logic [1:0]  rel;
        logic [1:0]  toggle;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   tests;
    int   failures;
    exp_t sb [$];

    button_conditioner_if #(.NUM_BTN(NB)) bif ();

    button_conditioner #(
        .NUM_BTN(NB),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [1:0] raw);
        bif.btn_raw = raw;
    endtask

    task automatic checkOutput(input exp_t e);
        tests += 4;
        assert (bif.btn_level === e.level) else begin
            failures++;
            $error("[TB] FAIL %s level: got %b expected %b", e.tag, bif.btn_level, e.level);
        end
        assert (bif.btn_press === e.press) else begin
            failures++;
            $error("[TB] FAIL %s press: got %b expected %b", e.tag, bif.btn_press, e.press);
        end
        assert (bif.btn_release === e.rel) else begin
            failures++;
            $error("[TB] FAIL %s release: got %b expected %b", e.tag, bif.btn_release, e.rel);
        end
        assert (bif.btn_toggle === e.toggle) else begin
            failures++;
            $error("[TB] FAIL %s toggle: got %b expected %b", e.tag, bif.btn_toggle, e.toggle);
        end
    endtask

    // Queue an expectation d posedges from now, keeping the queue ordered by cycle.
    task automatic expectAt(input int d, input string tag, input logic [1:0] lvl,
                            input logic [1:0] prs, input logic [1:0] rls, input logic [1:0] tgl);
        exp_t e;
        int   pos;
        e.cycle  = cyc + d;
        e.tag    = tag;
        e.level  = lvl;
        e.press  = prs;
        e.rel    = rls;
        e.toggle = tgl;
        pos = sb.size();
        for (int k = 0; k < sb.size(); k++) begin
            if (sb[k].cycle > e.cycle) begin
                pos = k;
                break;
            end
        end
        sb.insert(pos, e);
    endtask

    task automatic tick(input int n);
        exp_t e;
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            while (sb.size() > 0 && sb[0].cycle <= cyc) begin
                e = sb.pop_front();
                checkOutput(e);
            end
        end
    endtask

    task automatic holdFor(input logic [1:0] raw, input int n, input string tag,
                           input logic [1:0] lvl, input logic [1:0] tgl);
        applyStimulus(raw);
        for (int k = 0; k < n; k++) begin
            expectAt(1, tag, lvl, 2'b00, 2'b00, tgl);
            tick(1);
        end
    endtask

    initial begin
        exp_t z;
        cyc      = 0;
        tests    = 0;
        failures = 0;
        rst_n    = 1'b0;
        applyStimulus(2'b00);
        z.cycle = 0; z.level = 2'b00; z.press = 2'b00; z.rel = 2'b00; z.toggle = 2'b00;

        #3;
        z.tag = "reset";
        checkOutput(z);
        #9 rst_n = 1'b1;
        expectAt(1, "idle", 2'b00, 2'b00, 2'b00, 2'b00);
        expectAt(2, "idle", 2'b00, 2'b00, 2'b00, 2'b00);
        tick(2);

        // Clean press on channel 0
        applyStimulus(2'b01);
        expectAt(LAT-1, "t1_pre",   2'b00, 2'b00, 2'b00, 2'b00);
        expectAt(LAT,   "t1_press", 2'b01, 2'b01, 2'b00, 2'b01);
        expectAt(LAT+1, "t1_after", 2'b01, 2'b00, 2'b00, 2'b01);
        tick(LAT+2);

        // First release
        applyStimulus(2'b00);
        expectAt(LAT-1, "r1_pre",   2'b01, 2'b00, 2'b00, 2'b01);
        expectAt(LAT,   "r1_rel",   2'b00, 2'b00, 2'b01, 2'b01);
        expectAt(LAT+1, "r1_after", 2'b00, 2'b00, 2'b00, 2'b01);
        tick(LAT+2);

        // Bounce: 3 high, 1 low, 2 high, then low long enough to drain the pipeline
        holdFor(2'b01, 3, "t2_bounce", 2'b00, 2'b01);
        holdFor(2'b00, 1, "t2_bounce", 2'b00, 2'b01);
        holdFor(2'b01, 2, "t2_bounce", 2'b00, 2'b01);
        holdFor(2'b00, 6, "t2_quiet",  2'b00, 2'b01);

        // Second press: exact latency here shows the bounce left the counter at zero
        applyStimulus(2'b01);
        expectAt(LAT-1, "t3_pre",   2'b00, 2'b00, 2'b00, 2'b01);
        expectAt(LAT,   "t3_press", 2'b01, 2'b01, 2'b00, 2'b00);
        expectAt(LAT+1, "t3_after", 2'b01, 2'b00, 2'b00, 2'b00);
        tick(LAT+2);
        applyStimulus(2'b00);
        expectAt(LAT-1, "t3r_pre",   2'b01, 2'b00, 2'b00, 2'b00);
        expectAt(LAT,   "t3r_rel",   2'b00, 2'b00, 2'b01, 2'b00);
        expectAt(LAT+1, "t3r_after", 2'b00, 2'b00, 2'b00, 2'b00);
        tick(LAT+2);

        // Long hold: one press, steady level, no further pulses
        applyStimulus(2'b01);
        expectAt(LAT-1, "t6_pre",   2'b00, 2'b00, 2'b00, 2'b00);
        expectAt(LAT,   "t6_press", 2'b01, 2'b01, 2'b00, 2'b01);
        for (int k = LAT+1; k <= 100; k++) begin
            expectAt(k, "t6_hold", 2'b01, 2'b00, 2'b00, 2'b01);
        end
        tick(100);
        applyStimulus(2'b00);
        expectAt(LAT-1, "t6r_pre",   2'b01, 2'b00, 2'b00, 2'b01);
        expectAt(LAT,   "t6r_rel",   2'b00, 2'b00, 2'b01, 2'b01);
        expectAt(LAT+1, "t6r_after", 2'b00, 2'b00, 2'b00, 2'b01);
        tick(LAT+2);

        // Async reset while toggle[0]=1 and channel 1 is mid-count
        holdFor(2'b10, 4, "t5_count", 2'b00, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        z.tag = "t5_async";
        checkOutput(z);
        expectAt(1, "t5_inrst", 2'b00, 2'b00, 2'b00, 2'b00);
        expectAt(2, "t5_inrst", 2'b00, 2'b00, 2'b00, 2'b00);
        tick(2);
        #2 rst_n = 1'b1;
        expectAt(LAT-1, "t5_pre",   2'b00, 2'b00, 2'b00, 2'b00);
        expectAt(LAT,   "t5_press", 2'b10, 2'b10, 2'b00, 2'b10);
        expectAt(LAT+1, "t5_after", 2'b10, 2'b00, 2'b00, 2'b10);
        tick(LAT+2);

        // Clean restart, then both channels rise together
        rst_n = 1'b0;
        applyStimulus(2'b00);
        #2 rst_n = 1'b1;
        expectAt(2, "t4_idle", 2'b00, 2'b00, 2'b00, 2'b00);
        tick(3);
        applyStimulus(2'b11);
        expectAt(LAT-1, "t4_pre",   2'b00, 2'b00, 2'b00, 2'b00);
        expectAt(LAT,   "t4_press", 2'b11, 2'b11, 2'b00, 2'b11);
        expectAt(LAT+1, "t4_after", 2'b11, 2'b00, 2'b00, 2'b11);
        tick(LAT+2);
        applyStimulus(2'b00);
        expectAt(LAT,   "t4_rel",   2'b00, 2'b00, 2'b11, 2'b11);
        expectAt(LAT+1, "t4_done",  2'b00, 2'b00, 2'b00, 2'b11);
        tick(LAT+2);

        tests++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("[TB] FAIL sb_drain: got %0d pending expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
